// File: rtl/anita3_scaler_pkg.sv
// Shared definitions for the TURF scaler read port: address map, frame sizing and reader states.
package anita3_scaler_pkg;

    localparam int unsigned SCAL_ADDR_W = 6;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned SEQ_W       = 8;

    localparam logic [SCAL_ADDR_W-1:0] SCAL_ADDR_C3PO    = 6'h00;
    localparam logic [SCAL_ADDR_W-1:0] SCAL_ADDR_SEC     = 6'h04;
    localparam logic [SCAL_ADDR_W-1:0] SCAL_ADDR_L3_BASE = 6'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SEC,
        ST_OUT,
        ST_RD_C3PO,
        ST_RD_SCAL
    } reader_state_e;

    // Header word, C3PO word, then one word per four 8-bit L3 scalers.
    function automatic int unsigned frame_len(input int unsigned num_phi);
        return 32'(2 + num_phi / 2);
    endfunction

endpackage

// File: rtl/anita3_scaler_word_packer.sv
// Four-byte little-end-first shift register; packed_c presents the full word on the fourth byte.
module anita3_scaler_word_packer
    import anita3_scaler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [DATA_W-1:0] packed_c,
    output logic [1:0]        byte_cnt
);

    logic [DATA_W-BYTE_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (shift) begin
            shreg    <= {byte_in, shreg[DATA_W-BYTE_W-1:BYTE_W]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Incoming byte lands in the top lane so earlier bytes end up in the low lanes.
    assign packed_c = {byte_in, shreg};

endmodule

// File: rtl/anita3_scaler_reader.sv
// Per-PPS sequencer: reads seconds, C3PO and L3 scalers from the scaler port and streams a fixed frame.
module anita3_scaler_reader
    import anita3_scaler_pkg::*;
#(
    parameter int unsigned NUM_PHI = 16
) (
    input  logic                   clk33_i,
    input  logic                   rst_i,
    input  logic                   pps_i,
    output logic [SCAL_ADDR_W-1:0] scal_addr_o,
    input  logic [DATA_W-1:0]      scal_dat_i,
    output logic [DATA_W-1:0]      dat_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    localparam int unsigned FRAME_LEN = frame_len(NUM_PHI);
    localparam int unsigned WIDX_W    = $clog2(FRAME_LEN);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(FRAME_LEN - 1);

    reader_state_e state_q, state_d;
    logic [SCAL_ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0]      dat_d;
    logic                   valid_d, last_d, busy_d, overrun_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic                   miss_q, miss_d;
    logic                   frame_miss_q, frame_miss_d;
    logic [WIDX_W-1:0]      widx_q, widx_d;

    logic                   handshake, start, drop;
    logic [WIDX_W-1:0]      scal_word;
    logic [WIDX_W+1:0]      scal_off;
    logic [DATA_W-1:0]      packed_word;
    logic [1:0]             byte_cnt;

    assign handshake = valid_o && ready_i;
    // A PPS coinciding with the final handshake is a clean restart, not an overrun.
    assign start     = pps_i && ((state_q == ST_IDLE) || ((state_q == ST_OUT) && handshake && last_o));
    assign drop      = pps_i && !start && (state_q != ST_IDLE);
    assign scal_word = widx_q - WIDX_W'(1);
    assign scal_off  = {scal_word, 2'b00};

    anita3_scaler_word_packer u_packer (
        .clk      (clk33_i),
        .rst      (rst_i),
        .clr      (start),
        .shift    (state_q == ST_RD_SCAL),
        .byte_in  (scal_dat_i[BYTE_W-1:0]),
        .packed_c (packed_word),
        .byte_cnt (byte_cnt)
    );

    // State and registered outputs.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            scal_addr_o  <= '0;
            dat_o        <= '0;
            valid_o      <= 1'b0;
            last_o       <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
            seq_q        <= '0;
            miss_q       <= 1'b0;
            frame_miss_q <= 1'b0;
            widx_q       <= '0;
        end else begin
            state_q      <= state_d;
            scal_addr_o  <= addr_d;
            dat_o        <= dat_d;
            valid_o      <= valid_d;
            last_o       <= last_d;
            busy_o       <= busy_d;
            overrun_o    <= overrun_d;
            seq_q        <= seq_d;
            miss_q       <= miss_d;
            frame_miss_q <= frame_miss_d;
            widx_q       <= widx_d;
        end
    end

    // Next-state and next-output logic; widx_q is the index of the word held in dat_o.
    always_comb begin
        state_d      = state_q;
        addr_d       = scal_addr_o;
        dat_d        = dat_o;
        valid_d      = valid_o;
        last_d       = last_o;
        busy_d       = busy_o;
        overrun_d    = overrun_o;
        seq_d        = seq_q;
        miss_d       = miss_q;
        frame_miss_d = frame_miss_q;
        widx_d       = widx_q;

        if (drop) begin
            overrun_d = 1'b1;
            miss_d    = 1'b1;
        end

        case (state_q)
            ST_RD_SEC: begin
                dat_d   = {scal_dat_i[DATA_W-1:16], frame_miss_q, 7'b0, seq_q};
                valid_d = 1'b1;
                last_d  = 1'b0;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    widx_d  = widx_q + WIDX_W'(1);
                    if (last_o) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        seq_d   = seq_q + SEQ_W'(1);
                    end else if (widx_q == '0) begin
                        state_d = ST_RD_C3PO;
                        addr_d  = SCAL_ADDR_C3PO;
                    end else begin
                        state_d = ST_RD_SCAL;
                        addr_d  = SCAL_ADDR_L3_BASE + SCAL_ADDR_W'(scal_off);
                    end
                end
            end
            ST_RD_C3PO: begin
                dat_d   = scal_dat_i;
                valid_d = 1'b1;
                last_d  = (widx_q == LAST_IDX);
                state_d = ST_OUT;
            end
            ST_RD_SCAL: begin
                // Addresses run one cycle ahead of captures; the fourth capture completes the word.
                if (byte_cnt == 2'd3) begin
                    dat_d   = packed_word;
                    valid_d = 1'b1;
                    last_d  = (widx_q == LAST_IDX);
                    state_d = ST_OUT;
                end else begin
                    addr_d = scal_addr_o + SCAL_ADDR_W'(1);
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d      = ST_RD_SEC;
            addr_d       = SCAL_ADDR_SEC;
            busy_d       = 1'b1;
            widx_d       = '0;
            frame_miss_d = miss_q;
            miss_d       = 1'b0;
        end
    end

endmodule

// File: tb/tb_anita3_scaler_reader.sv
// Self-checking bench for anita3_scaler_reader with a scaler-port model and a frame reference model.
module tb_anita3_scaler_reader;

    localparam int NUM_PHI = 16;
    localparam int FLEN    = 2 + NUM_PHI / 2;
    localparam int NSCAL   = 2 * NUM_PHI;
    localparam int NB2B    = 257;
    localparam int FPER    = 44;

    logic        clk33_i = 1'b0;
    logic        rst_i   = 1'b1;
    logic        pps_i   = 1'b0;
    logic        ready_i = 1'b1;
    logic [5:0]  scal_addr_o;
    logic [31:0] scal_dat_i;
    logic [31:0] dat_o;
    logic        valid_o, last_o, busy_o, overrun_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] m_sec;
    logic [31:0] m_c3po;
    logic [7:0]  m_s [NSCAL];
    logic [31:0] exp_w [FLEN];

    logic [31:0] q_dat [$];
    bit          q_last [$];
    int          q_edge [$];
    int          stall_viol   = 0;
    int          stall_cycles = 0;
    bit          prev_stall   = 1'b0;
    logic [31:0] prev_dat     = '0;
    logic        prev_last    = 1'b0;

    anita3_scaler_reader #(.NUM_PHI(NUM_PHI)) dut (
        .clk33_i     (clk33_i),
        .rst_i       (rst_i),
        .pps_i       (pps_i),
        .scal_addr_o (scal_addr_o),
        .scal_dat_i  (scal_dat_i),
        .dat_o       (dat_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    always #15 clk33_i = ~clk33_i;

    always @(posedge clk33_i) cyc <= cyc + 1;

    // Scaler port model; junk in unused upper bits of scaler reads.
    always_comb begin
        if (scal_addr_o == 6'h04)      scal_dat_i = {m_sec, 16'h0000};
        else if (scal_addr_o == 6'h00) scal_dat_i = m_c3po;
        else if (scal_addr_o[5])       scal_dat_i = {16'hBEEF, 2'b00, scal_addr_o, m_s[scal_addr_o[4:0]]};
        else                           scal_dat_i = 32'hBAD0BAD0;
    end

    // Stream monitor: records accepted words and stall stability violations.
    always @(negedge clk33_i) begin
        if (!rst_i) begin
            if (prev_stall && (valid_o !== 1'b1 || dat_o !== prev_dat || last_o !== prev_last))
                stall_viol <= stall_viol + 1;
            if (valid_o && ready_i) begin
                q_dat.push_back(dat_o);
                q_last.push_back(last_o);
                q_edge.push_back(cyc + 1);
            end
            if (valid_o && !ready_i) stall_cycles <= stall_cycles + 1;
        end
        prev_stall <= !rst_i && valid_o && !ready_i;
        prev_dat   <= dat_o;
        prev_last  <= last_o;
    end

    initial begin
        #(30 * 90000);
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic model_frame(input logic miss, input logic [7:0] seq);
        exp_w[0] = {m_sec, miss, 7'b0, seq};
        exp_w[1] = m_c3po;
        for (int k = 0; k < NUM_PHI / 2; k++)
            exp_w[2 + k] = {m_s[4*k+3], m_s[4*k+2], m_s[4*k+1], m_s[4*k]};
    endtask

    task automatic rand_scaler();
        m_sec  = 16'($urandom);
        m_c3po = $urandom;
        for (int n = 0; n < NSCAL; n++) m_s[n] = 8'($urandom);
    endtask

    task automatic clear_q();
        q_dat.delete();
        q_last.delete();
        q_edge.delete();
    endtask

    task automatic tick();
        @(posedge clk33_i);
        #1;
    endtask

    // Returns at edge T + 1 time unit, where T is the edge that samples pps_i.
    task automatic send_pps(output int t);
        tick();
        pps_i = 1'b1;
        t = cyc + 1;
        tick();
        pps_i = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (q_dat.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (q_dat.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; pps_i = 1'b1; ready_i = 1'b1;
        repeat (3) tick();
        pps_i = 1'b0;
        checks++; if (scal_addr_o !== 6'h00) begin failures++; $display("FAIL reset_addr: got %h want 00", scal_addr_o); end
        checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat: got %h want 0", dat_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (last_o !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", last_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        rst_i = 1'b0;
        repeat (3) tick();
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL reset_pps_ignored: busy %b valid %b want 0 0", busy_o, valid_o); end
    endtask

    task automatic test_basic();
        int t; bit ok; int nlast;
        m_sec = 16'h1234; m_c3po = 32'h0EE6B280;
        for (int n = 0; n < NSCAL; n++) m_s[n] = 8'(n + 1);
        model_frame(1'b0, 8'd0);
        clear_q();
        ready_i = 1'b1;
        send_pps(t);
        checks++; if (scal_addr_o !== 6'h04 || busy_o !== 1'b1) begin failures++; $display("FAIL basic_start: addr %h busy %b want 04 1", scal_addr_o, busy_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || dat_o !== 32'h12340000) begin failures++; $display("FAIL basic_word0_early: valid %b dat %h want 1 12340000", valid_o, dat_o); end
        wait_words(FLEN, 100, ok);
        repeat (4) tick();
        checks++; if (!ok || q_dat.size() != FLEN) begin failures++; $display("FAIL basic_count: got %0d words want %0d", q_dat.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL basic_word%0d: got %h want %h", i, (i < q_dat.size()) ? q_dat[i] : 32'hx, exp_w[i]);
            end
        end
        nlast = 0;
        foreach (q_last[i]) if (q_last[i]) nlast++;
        checks++; if (nlast != 1 || q_last.size() != FLEN || !q_last[FLEN-1]) begin failures++; $display("FAIL basic_last: got %0d last flags want exactly one on word %0d", nlast, FLEN - 1); end
        if (q_edge.size() == FLEN) begin
            checks++; if (q_edge[0] != t + 2) begin failures++; $display("FAIL basic_t_w0: got T+%0d want T+2", q_edge[0] - t); end
            checks++; if (q_edge[1] != t + 4) begin failures++; $display("FAIL basic_t_w1: got T+%0d want T+4", q_edge[1] - t); end
            checks++; if (q_edge[2] != t + 9) begin failures++; $display("FAIL basic_t_w2: got T+%0d want T+9", q_edge[2] - t); end
            checks++; if (q_edge[FLEN-1] != t + 44) begin failures++; $display("FAIL basic_t_last: got T+%0d want T+44", q_edge[FLEN-1] - t); end
        end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_backpressure();
        int t; int nlast;
        rand_scaler();
        model_frame(1'b0, 8'd1);
        clear_q();
        stall_cycles = 0;
        send_pps(t);
        for (int i = 0; i < 600; i++) begin
            if (q_dat.size() >= FLEN) break;
            tick();
            ready_i = 1'($urandom_range(0, 1));
        end
        ready_i = 1'b1;
        repeat (6) tick();
        checks++; if (q_dat.size() != FLEN) begin failures++; $display("FAIL bp_count: got %0d words want %0d", q_dat.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL bp_word%0d: got %h want %h", i, (i < q_dat.size()) ? q_dat[i] : 32'hx, exp_w[i]);
            end
        end
        nlast = 0;
        foreach (q_last[i]) if (q_last[i]) nlast++;
        checks++; if (nlast != 1 || q_last.size() != FLEN || !q_last[FLEN-1]) begin failures++; $display("FAIL bp_last: got %0d last flags want one on final word", nlast); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_viol); end
        checks++; if (stall_cycles == 0) begin failures++; $display("FAIL bp_stalled: got %0d stall cycles want >0", stall_cycles); end
    endtask

    task automatic test_pps_during_frame();
        int t; bit ok;
        rand_scaler();
        // Frame A: second PPS lands mid-frame.
        model_frame(1'b0, 8'd2);
        clear_q();
        send_pps(t);
        repeat (19) tick();
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_before: got %b want 0", overrun_o); end
        pps_i = 1'b1;
        tick();
        pps_i = 1'b0;
        tick();
        checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b want 1 at T+21", overrun_o); end
        wait_words(FLEN, 100, ok);
        repeat (3) tick();
        checks++; if (!ok || q_dat.size() != FLEN || q_edge[FLEN-1] != t + 44) begin failures++; $display("FAIL ovr_frame_a_len: got %0d words want %0d ending T+44", q_dat.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp_w[i]) begin failures++; $display("FAIL ovr_a_word%0d: got %h want %h", i, (i < q_dat.size()) ? q_dat[i] : 32'hx, exp_w[i]); end
        end
        // Frame B reports the miss, frame C does not.
        for (int f = 0; f < 2; f++) begin
            model_frame(f == 0, 8'(3 + f));
            clear_q();
            send_pps(t);
            wait_words(FLEN, 100, ok);
            repeat (3) tick();
            checks++; if (q_dat.size() < 1 || q_dat[0][15] !== (f == 0)) begin failures++; $display("FAIL ovr_miss_frame%0d: got word0 %h want bit15=%0d", f + 1, (q_dat.size() > 0) ? q_dat[0] : 32'hx, f == 0); end
            for (int i = 0; i < FLEN; i++) begin
                checks++;
                if (i >= q_dat.size() || q_dat[i] !== exp_w[i]) begin failures++; $display("FAIL ovr_f%0d_word%0d: got %h want %h", f + 1, i, (i < q_dat.size()) ? q_dat[i] : 32'hx, exp_w[i]); end
            end
        end
        checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b want 1", overrun_o); end
    endtask

    task automatic test_back_to_back();
        int t0; int nbad; int first_bad;
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        rand_scaler();
        clear_q();
        ready_i = 1'b1;
        tick();
        t0 = cyc + 1;
        for (int c = 0; c < NB2B * FPER; c++) begin
            pps_i = (c % FPER == 0);
            tick();
        end
        pps_i = 1'b0;
        repeat (6) tick();
        checks++; if (q_dat.size() != NB2B * FLEN) begin failures++; $display("FAIL b2b_count: got %0d words want %0d", q_dat.size(), NB2B * FLEN); end
        nbad = 0; first_bad = -1;
        for (int f = 0; f < NB2B; f++) begin
            model_frame(1'b0, 8'(f));
            for (int i = 0; i < FLEN; i++) begin
                if (f * FLEN + i >= q_dat.size() || q_dat[f*FLEN+i] !== exp_w[i] || q_last[f*FLEN+i] !== (i == FLEN - 1)) begin
                    nbad++;
                    if (first_bad < 0) first_bad = f * FLEN + i;
                end
            end
        end
        checks++; if (nbad != 0) begin failures++; $display("FAIL b2b_words: got %0d bad words (first at %0d) want 0", nbad, first_bad); end
        if (q_dat.size() == NB2B * FLEN) begin
            checks++; if (q_dat[FLEN][7:0] !== 8'd1) begin failures++; $display("FAIL b2b_seq1: got %0d want 1", q_dat[FLEN][7:0]); end
            checks++; if (q_dat[256*FLEN][7:0] !== 8'd0) begin failures++; $display("FAIL b2b_seq_wrap: got %0d want 0", q_dat[256*FLEN][7:0]); end
            checks++; if (q_edge[NB2B*FLEN-1] != t0 + NB2B * FPER) begin failures++; $display("FAIL b2b_timing: got end T+%0d want T+%0d", q_edge[NB2B*FLEN-1] - t0, NB2B * FPER); end
        end
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b want 0", overrun_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid_frame();
        int t; bit ok;
        rand_scaler();
        send_pps(t);
        repeat (9) tick();
        rst_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || scal_addr_o !== 6'h00 || last_o !== 1'b0) begin
            failures++; $display("FAIL rst_mid: valid %b busy %b addr %h last %b want 0 0 00 0", valid_o, busy_o, scal_addr_o, last_o);
        end
        rst_i = 1'b0;
        tick();
        clear_q();
        model_frame(1'b0, 8'd0);
        send_pps(t);
        wait_words(FLEN, 100, ok);
        repeat (3) tick();
        checks++; if (!ok || q_dat.size() != FLEN) begin failures++; $display("FAIL rst_mid_count: got %0d words want %0d", q_dat.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp_w[i]) begin failures++; $display("FAIL rst_mid_word%0d: got %h want %h", i, (i < q_dat.size()) ? q_dat[i] : 32'hx, exp_w[i]); end
        end
    endtask

    initial begin
        for (int n = 0; n < NSCAL; n++) m_s[n] = '0;
        m_sec = '0; m_c3po = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_pps_during_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
